// File: rtl/scalar_scoreboard_ctrl.sv
// Scoreboard controller for the scalar FUs: dispatch admission, operand issue,
// and round-robin, WAR-safe arbitration of the single regfile write port.
module scalar_scoreboard_ctrl #(
    parameter int NUM_FU = 3,
    parameter int REG_W  = 5,
    parameter int FU_S_W = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     disp_valid,
    input  logic [FU_S_W-1:0]        disp_fu,
    input  logic [REG_W-1:0]         disp_rd,
    input  logic [REG_W-1:0]         disp_rs1,
    input  logic [REG_W-1:0]         disp_rs2,
    output logic                     disp_ready,
    output logic [NUM_FU-1:0]        issue_valid,
    input  logic [NUM_FU-1:0]        issue_ready,
    output logic [NUM_FU*REG_W-1:0]  issue_rs1,
    output logic [NUM_FU*REG_W-1:0]  issue_rs2,
    input  logic [NUM_FU-1:0]        wb_req,
    output logic [NUM_FU-1:0]        wb_grant,
    output logic [REG_W-1:0]         wb_rd,
    input  logic                     flush,
    output logic [NUM_FU-1:0]        fu_busy
);

    localparam int NUM_REG  = 1 << REG_W;
    localparam int FU_SLOTS = 1 << FU_S_W;

    logic [NUM_FU-1:0] busy_q;
    logic [NUM_FU-1:0] issued_q;
    logic [REG_W-1:0]  r_q  [NUM_FU];
    logic [REG_W-1:0]  r1_q [NUM_FU];
    logic [REG_W-1:0]  r2_q [NUM_FU];
    logic [FU_S_W-1:0] t1_q [NUM_FU];
    logic [FU_S_W-1:0] t2_q [NUM_FU];
    logic [FU_S_W-1:0] rstat_q [NUM_REG];
    logic [FU_S_W-1:0] ptr_q;

    logic [FU_SLOTS-1:0] busy_ext;
    logic                disp_acc;
    logic [FU_S_W-1:0]   disp_tag;
    logic [FU_S_W-1:0]   cap_t1;
    logic [FU_S_W-1:0]   cap_t2;
    logic [NUM_FU-1:0]   war_hit;
    logic [NUM_FU-1:0]   elig;
    logic                grant_any;
    logic [FU_S_W-1:0]   gidx;
    logic [FU_S_W-1:0]   gtag;

    // Nonexistent FU slots read as busy so an illegal disp_fu is never accepted.
    always_comb begin
        busy_ext = '1;
        for (int i = 0; i < NUM_FU; i++) busy_ext[i] = busy_q[i];
    end

    assign disp_ready = !RST && !flush && (int'(disp_fu) < NUM_FU) && !busy_ext[disp_fu]
                        && (disp_rd == '0 || rstat_q[disp_rd] == '0);
    assign disp_acc   = disp_valid && disp_ready;
    assign disp_tag   = disp_fu + FU_S_W'(1);
    assign fu_busy    = busy_q;

    always_comb begin
        issue_valid = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            issue_valid[i] = !RST && !flush && busy_q[i] && !issued_q[i]
                             && t1_q[i] == '0 && t2_q[i] == '0;
            issue_rs1[i*REG_W +: REG_W] = r1_q[i];
            issue_rs2[i*REG_W +: REG_W] = r2_q[i];
        end
    end

    // A writer must wait while any not-yet-issued reader still needs the old value.
    always_comb begin
        war_hit = '0;
        elig    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (j != i && busy_q[j] && !issued_q[j]
                    && ((r1_q[j] == r_q[i] && t1_q[j] == '0)
                        || (r2_q[j] == r_q[i] && t2_q[j] == '0)))
                    war_hit[i] = 1'b1;
            end
            elig[i] = wb_req[i] && busy_q[i] && issued_q[i]
                      && !(war_hit[i] && r_q[i] != '0);
        end
    end

    always_comb begin
        int idx;
        wb_grant  = '0;
        grant_any = 1'b0;
        gidx      = '0;
        for (int k = 1; k <= NUM_FU; k++) begin
            idx = (int'(ptr_q) + k) % NUM_FU;
            if (!grant_any && elig[idx]) begin
                grant_any = 1'b1;
                gidx      = FU_S_W'(idx);
            end
        end
        if (RST || flush) grant_any = 1'b0;
        if (grant_any) wb_grant[gidx] = 1'b1;
    end

    assign gtag  = gidx + FU_S_W'(1);
    assign wb_rd = grant_any ? r_q[gidx] : '0;

    // Same-cycle writeback of the producer counts as already available.
    always_comb begin
        cap_t1 = (disp_rs1 == '0) ? '0 : rstat_q[disp_rs1];
        cap_t2 = (disp_rs2 == '0) ? '0 : rstat_q[disp_rs2];
        if (grant_any && cap_t1 == gtag) cap_t1 = '0;
        if (grant_any && cap_t2 == gtag) cap_t2 = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            busy_q   <= '0;
            issued_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_q[i]  <= '0;
                r1_q[i] <= '0;
                r2_q[i] <= '0;
                t1_q[i] <= '0;
                t2_q[i] <= '0;
            end
            for (int r = 0; r < NUM_REG; r++) rstat_q[r] <= '0;
            if (RST) ptr_q <= FU_S_W'(NUM_FU - 1);
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (issue_valid[i] && issue_ready[i]) issued_q[i] <= 1'b1;
            end
            if (grant_any) begin
                ptr_q          <= gidx;
                busy_q[gidx]   <= 1'b0;
                issued_q[gidx] <= 1'b0;
                if (rstat_q[r_q[gidx]] == gtag) rstat_q[r_q[gidx]] <= '0;
                for (int i = 0; i < NUM_FU; i++) begin
                    if (t1_q[i] == gtag) t1_q[i] <= '0;
                    if (t2_q[i] == gtag) t2_q[i] <= '0;
                end
            end
            // Placed after the grant updates so a same-rd dispatch owns RSTAT.
            if (disp_acc) begin
                busy_q[disp_fu]   <= 1'b1;
                issued_q[disp_fu] <= 1'b0;
                r_q[disp_fu]      <= disp_rd;
                r1_q[disp_fu]     <= disp_rs1;
                r2_q[disp_fu]     <= disp_rs2;
                t1_q[disp_fu]     <= cap_t1;
                t2_q[disp_fu]     <= cap_t2;
                if (disp_rd != '0) rstat_q[disp_rd] <= disp_tag;
            end
        end
    end

endmodule

// File: tb/tb_scalar_scoreboard_ctrl.sv
// Directed bench for scalar_scoreboard_ctrl; writebacks are checked by a
// negedge monitor against a queue of expected {grant, rd} pairs.
module tb_scalar_scoreboard_ctrl;

    logic        CLK;
    logic        RST;
    logic        disp_valid;
    logic [1:0]  disp_fu;
    logic [4:0]  disp_rd, disp_rs1, disp_rs2;
    logic        disp_ready;
    logic [2:0]  issue_valid;
    logic [2:0]  issue_ready;
    logic [14:0] issue_rs1, issue_rs2;
    logic [2:0]  wb_req;
    logic [2:0]  wb_grant;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [2:0]  fu_busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    bit          armed = 0;

    scalar_scoreboard_ctrl dut (
        .CLK(CLK), .RST(RST),
        .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_ready(disp_ready),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .wb_req(wb_req), .wb_grant(wb_grant), .wb_rd(wb_rd),
        .flush(flush), .fu_busy(fu_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wb(input logic [2:0] g, input logic [4:0] rd);
        exp_q.push_back({g, rd});
        armed = 1'b1;
    endtask

    // Advance to just after the next edge and return inputs to idle.
    task automatic cyc();
        @(posedge CLK);
        #1;
        RST = 0; flush = 0; disp_valid = 0; disp_fu = 0; disp_rd = 0;
        disp_rs1 = 0; disp_rs2 = 0; issue_ready = 0; wb_req = 0;
        if (armed) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL wb_missing: %0d expected grants not seen, expected 0", exp_q.size());
                exp_q.delete();
            end
            armed = 1'b0;
        end
    endtask

    task automatic disp(input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic exp_rdy, input string name);
        disp_valid = 1; disp_fu = fu; disp_rd = rd; disp_rs1 = rs1; disp_rs2 = rs2;
        #1 chk(name, disp_ready, exp_rdy);
    endtask

    task automatic probe(input logic [1:0] fu, input logic [4:0] rd, input logic exp_rdy,
                         input string name);
        disp_valid = 0; disp_fu = fu; disp_rd = rd; disp_rs1 = 0; disp_rs2 = 0;
        #1 chk(name, disp_ready, exp_rdy);
    endtask

    always @(negedge CLK) begin
        if (wb_grant !== 3'b000) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got grant %b rd %0d expected no grant", wb_grant, wb_rd);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({wb_grant, wb_rd} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL wb_grant: got grant %b rd %0d expected grant %b rd %0d",
                             wb_grant, wb_rd, mon_exp[7:5], mon_exp[4:0]);
                end
            end
        end
    end

    initial begin
        RST = 1; flush = 0; disp_valid = 0; disp_fu = 0; disp_rd = 0;
        disp_rs1 = 0; disp_rs2 = 0; issue_ready = 0; wb_req = 0;
        @(posedge CLK);
        #1;
        disp(0, 5, 0, 0, 0, "rst_disp_ready");
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_fu_busy", fu_busy, 0);
        cyc();

        // independent dispatch
        disp(0, 5, 1, 2, 1, "ind_disp");
        chk("ind_no_issue_yet", issue_valid, 0);
        cyc();
        chk("ind_busy", fu_busy, 3'b001);
        chk("ind_issue_valid", issue_valid, 3'b001);
        chk("ind_rs1", issue_rs1[4:0], 1);
        chk("ind_rs2", issue_rs2[4:0], 2);
        issue_ready = 3'b001;
        cyc();
        chk("ind_issued", issue_valid, 0);
        probe(1, 5, 0, "ind_rstat5_pending");
        wb_req = 3'b001; exp_wb(3'b001, 5);
        cyc();
        chk("ind_idle", fu_busy, 0);
        probe(1, 5, 1, "ind_rstat5_clear");
        cyc();

        // RAW chain
        disp(0, 5, 0, 0, 1, "raw_disp_alu");
        cyc();
        chk("raw_alu_iv", issue_valid, 3'b001);
        disp(1, 6, 5, 0, 1, "raw_disp_ldst");
        issue_ready = 3'b001;
        cyc();
        chk("raw_ldst_wait", issue_valid, 0);
        wb_req = 3'b001; exp_wb(3'b001, 5);
        cyc();
        chk("raw_ldst_iv", issue_valid, 3'b010);
        chk("raw_ldst_rs1", issue_rs1[9:5], 5);
        issue_ready = 3'b010;
        cyc();
        wb_req = 3'b010; exp_wb(3'b010, 6);
        cyc();

        // RAW with dispatch in the producer's grant cycle
        disp(0, 5, 0, 0, 1, "byp_disp_alu");
        cyc();
        issue_ready = 3'b001;
        cyc();
        wb_req = 3'b001; exp_wb(3'b001, 5);
        disp(1, 6, 5, 0, 1, "byp_disp_ldst");
        cyc();
        chk("byp_ldst_iv", issue_valid, 3'b010);
        issue_ready = 3'b010;
        cyc();
        wb_req = 3'b010; exp_wb(3'b010, 6);
        cyc();

        // WAW stall
        disp(0, 7, 0, 0, 1, "waw_disp_alu");
        cyc();
        probe(2, 7, 0, "waw_stall");
        probe(2, 0, 1, "waw_rd0_ok");
        issue_ready = 3'b001;
        cyc();
        probe(2, 7, 0, "waw_no_bypass");
        probe(0, 8, 0, "freed_row_same_cycle");
        wb_req = 3'b001; exp_wb(3'b001, 7);
        cyc();
        probe(2, 7, 1, "waw_released");
        disp(3, 0, 0, 0, 0, "illegal_fu");
        cyc();
        chk("illegal_fu_dropped", fu_busy, 0);

        // WAR hold
        disp(1, 10, 0, 9, 1, "war_disp_ldst");
        cyc();
        disp(0, 9, 0, 0, 1, "war_disp_alu");
        cyc();
        chk("war_both_iv", issue_valid, 3'b011);
        issue_ready = 3'b001;
        cyc();
        wb_req = 3'b001;
        #1 chk("war_hold1", wb_grant, 0);
        cyc();
        wb_req = 3'b001; issue_ready = 3'b010;
        #1 chk("war_hold2", wb_grant, 0);
        cyc();
        wb_req = 3'b001; exp_wb(3'b001, 9);
        cyc();
        wb_req = 3'b010; exp_wb(3'b010, 10);
        cyc();

        // fairness, pointer currently at FU1
        disp(0, 11, 0, 0, 1, "rr_disp0");
        cyc();
        disp(1, 12, 0, 0, 1, "rr_disp1");
        issue_ready = 3'b001;
        cyc();
        disp(2, 13, 0, 0, 1, "rr_disp2");
        issue_ready = 3'b010;
        cyc();
        issue_ready = 3'b100;
        cyc();
        chk("rr_all_busy", fu_busy, 3'b111);
        wb_req = 3'b111; exp_wb(3'b100, 13);
        cyc();
        wb_req = 3'b111; exp_wb(3'b001, 11);
        cyc();
        wb_req = 3'b111; exp_wb(3'b010, 12);
        cyc();
        disp(0, 14, 0, 0, 1, "rr101_disp0");
        cyc();
        disp(2, 15, 0, 0, 1, "rr101_disp2");
        issue_ready = 3'b001;
        cyc();
        issue_ready = 3'b100;
        cyc();
        wb_req = 3'b101; exp_wb(3'b100, 15);
        cyc();
        wb_req = 3'b101; exp_wb(3'b001, 14);
        cyc();

        // reset mid-operation
        disp(0, 5, 0, 0, 1, "rstm_disp_alu");
        cyc();
        disp(1, 6, 5, 0, 1, "rstm_disp_ldst");
        cyc();
        RST = 1;
        probe(2, 20, 0, "rstm_disp_ready_low");
        cyc();
        chk("rstm_busy", fu_busy, 0);
        chk("rstm_iv", issue_valid, 0);
        probe(1, 6, 1, "rstm_rstat6_clear");
        disp(0, 5, 0, 0, 1, "rstm_fresh_disp");
        cyc();
        chk("rstm_fresh_iv", issue_valid, 3'b001);
        issue_ready = 3'b001;
        cyc();
        wb_req = 3'b001; exp_wb(3'b001, 5);
        cyc();

        // flush mid-operation, pointer now at FU0
        disp(0, 16, 0, 0, 1, "fl_disp_alu");
        cyc();
        disp(1, 17, 16, 0, 1, "fl_disp_ldst");
        cyc();
        disp(2, 18, 0, 0, 1, "fl_disp_br");
        issue_ready = 3'b001;
        cyc();
        flush = 1; wb_req = 3'b001;
        #1;
        chk("fl_iv_suppressed", issue_valid, 0);
        chk("fl_grant_suppressed", wb_grant, 0);
        cyc();
        chk("fl_busy", fu_busy, 0);
        probe(0, 16, 1, "fl_rstat16_clear");
        disp(0, 5, 0, 0, 1, "fl_fresh_disp");
        cyc();
        disp(1, 21, 0, 0, 1, "fl_disp_ldst2");
        issue_ready = 3'b001;
        cyc();
        issue_ready = 3'b010;
        cyc();
        wb_req = 3'b011; exp_wb(3'b010, 21);
        cyc();
        wb_req = 3'b011; exp_wb(3'b001, 5);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
